// File: rtl/mem_arbiter.sv
// Single-port arbiter and sequencer for shared main memory. The loader, video DMA and
// CPU share one registered access slot with a fixed read latency and a CPU starvation guard.
module mem_arbiter #(
  parameter int ADDR_W     = 25,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_active,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_wdata,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              ld_ack,
  output logic              dma_ack,
  output logic              cpu_ack,
  output logic [7:0]        rdata,
  output logic [1:0]        grant,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_we,
  output logic              mem_rd,
  input  logic [7:0]        mem_dout
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_LD   = 2'd1;
  localparam logic [1:0] G_DMA  = 2'd2;
  localparam logic [1:0] G_CPU  = 2'd3;

  logic [1:0] state;
  logic [3:0] lat_cnt;
  logic [3:0] starve_cnt;
  logic       op_wr;
  logic [1:0] win;

  function automatic logic [3:0] starve_inc(input logic [3:0] c);
    return (c >= 4'(STARVE_MAX)) ? 4'(STARVE_MAX) : c + 4'd1;
  endfunction

  // Loader always wins; a download in progress otherwise locks everyone out.
  always_comb begin
    win = G_NONE;
    if (ld_req) begin
      win = G_LD;
    end else if (!ld_active) begin
      if (cpu_req && (starve_cnt == 4'(STARVE_MAX))) win = G_CPU;
      else if (dma_req)                              win = G_DMA;
      else if (cpu_req)                              win = G_CPU;
    end
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      op_wr      <= 1'b0;
      grant      <= G_NONE;
      ld_ack     <= 1'b0;
      dma_ack    <= 1'b0;
      cpu_ack    <= 1'b0;
      rdata      <= '0;
      mem_addr   <= '0;
      mem_din    <= '0;
      mem_we     <= 1'b0;
      mem_rd     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if ((win == G_CPU) || !cpu_req) starve_cnt <= '0;
          else if (win == G_DMA)          starve_cnt <= starve_inc(starve_cnt);
          if (win != G_NONE) begin
            grant <= win;
            state <= S_ISSUE;
            case (win)
              G_LD: begin
                mem_addr <= ld_addr;
                mem_din  <= ld_wdata;
                op_wr    <= 1'b1;
                mem_we   <= 1'b1;
              end
              G_DMA: begin
                mem_addr <= dma_addr;
                op_wr    <= 1'b0;
                mem_rd   <= 1'b1;
              end
              default: begin
                mem_addr <= cpu_addr;
                mem_din  <= cpu_wdata;
                op_wr    <= cpu_we;
                mem_we   <= cpu_we;
                mem_rd   <= ~cpu_we;
              end
            endcase
          end
        end
        S_ISSUE: begin
          mem_we  <= 1'b0;
          mem_rd  <= 1'b0;
          lat_cnt <= 4'(RD_LAT);
          state   <= S_WAIT;
        end
        // Writes ride the same latency as reads so every access has identical timing.
        S_WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt == 4'd1) begin
            if (!op_wr) rdata <= mem_dout;
            ld_ack  <= (grant == G_LD);
            dma_ack <= (grant == G_DMA);
            cpu_ack <= (grant == G_CPU);
            state   <= S_DONE;
          end
        end
        default: begin
          ld_ack  <= 1'b0;
          dma_ack <= 1'b0;
          cpu_ack <= 1'b0;
          grant   <= G_NONE;
          state   <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-level model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_mem_arbiter;
  localparam int ADDR_W     = 25;
  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 4;
  localparam int DONE_PH    = RD_LAT + 2;

  logic clk = 1'b0;
  logic reset, ld_active, ld_req, dma_req, cpu_req, cpu_we;
  logic [ADDR_W-1:0] ld_addr, dma_addr, cpu_addr, mem_addr;
  logic [7:0] ld_wdata, cpu_wdata, rdata, mem_din, mem_dout;
  logic ld_ack, dma_ack, cpu_ack, busy, mem_we, mem_rd;
  logic [1:0] grant;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset), .ld_active(ld_active), .ld_req(ld_req), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .dma_req(dma_req), .dma_addr(dma_addr), .cpu_req(cpu_req),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .ld_ack(ld_ack),
    .dma_ack(dma_ack), .cpu_ack(cpu_ack), .rdata(rdata), .grant(grant), .busy(busy),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_rd(mem_rd),
    .mem_dout(mem_dout)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory seen by the DUT and the model's own shadow copy.
  logic [7:0] dmem [int];
  logic [7:0] smem [int];

  function automatic logic [7:0] dflt(input int a);
    return 8'(a) ^ 8'h3C;
  endfunction

  function automatic logic [7:0] rd_dmem(input int a);
    if (dmem.exists(a)) return dmem[a];
    return dflt(a);
  endfunction

  function automatic logic [7:0] rd_smem(input int a);
    if (smem.exists(a)) return smem[a];
    return dflt(a);
  endfunction

  logic [7:0] pipe [RD_LAT];
  always @(posedge clk) begin
    pipe[0] <= mem_rd ? rd_dmem(int'(mem_addr)) : 8'h00;
    for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
  end
  always @(posedge clk) if (mem_we) dmem[int'(mem_addr)] = mem_din;
  assign mem_dout = pipe[RD_LAT-1];

  // Transaction model: an access occupies DONE_PH+1 cycles after its grant edge.
  bit m_act = 0;
  int m_phase = 0;
  int m_starve = 0;
  logic [1:0] m_owner = 2'd0;
  logic m_we = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [7:0] m_din = 8'h00, m_rdata = 8'h00, m_rd_val = 8'h00;

  always @(posedge clk) begin
    logic [1:0] w;
    w = 2'd0;
    if (reset) begin
      m_act = 0; m_phase = 0; m_starve = 0; m_owner = 2'd0; m_we = 1'b0;
      m_addr = '0; m_din = 8'h00; m_rdata = 8'h00;
    end else if (m_act) begin
      m_phase++;
      if (m_phase == DONE_PH && !m_we) m_rdata = m_rd_val;
      if (m_phase > DONE_PH) begin
        m_act = 0;
        m_owner = 2'd0;
      end
    end else begin
      if (ld_req) w = 2'd1;
      else if (!ld_active) begin
        if (cpu_req && m_starve == STARVE_MAX) w = 2'd3;
        else if (dma_req)                      w = 2'd2;
        else if (cpu_req)                      w = 2'd3;
      end
      if (w == 2'd3 || !cpu_req) m_starve = 0;
      else if (w == 2'd2 && m_starve < STARVE_MAX) m_starve++;
      if (w != 2'd0) begin
        m_act = 1; m_phase = 1; m_owner = w;
        case (w)
          2'd1:    begin m_addr = ld_addr; m_din = ld_wdata; m_we = 1'b1; end
          2'd2:    begin m_addr = dma_addr; m_we = 1'b0; end
          default: begin m_addr = cpu_addr; m_din = cpu_wdata; m_we = cpu_we; end
        endcase
        if (m_we) smem[int'(m_addr)] = m_din;
        else      m_rd_val = rd_smem(int'(m_addr));
      end
    end
  end

  bit chk_en = 0;
  always @(negedge clk) if (chk_en) begin
    check("m_grant",   32'(grant),   32'(m_owner));
    check("m_busy",    32'(busy),    32'(m_act));
    check("m_mem_we",  32'(mem_we),  32'(m_act && m_phase == 1 && m_we));
    check("m_mem_rd",  32'(mem_rd),  32'(m_act && m_phase == 1 && !m_we));
    check("m_ld_ack",  32'(ld_ack),  32'(m_act && m_phase == DONE_PH && m_owner == 2'd1));
    check("m_dma_ack", 32'(dma_ack), 32'(m_act && m_phase == DONE_PH && m_owner == 2'd2));
    check("m_cpu_ack", 32'(cpu_ack), 32'(m_act && m_phase == DONE_PH && m_owner == 2'd3));
    check("m_rdata",   32'(rdata),   32'(m_rdata));
    check("m_addr",    32'(mem_addr), 32'(m_addr));
    check("m_din",     32'(mem_din), 32'(m_din));
  end

  int c_ld, c_dma, c_cpu, c_we, c_rd;
  logic [1:0] seq [$];

  task automatic clr();
    c_ld = 0; c_dma = 0; c_cpu = 0; c_we = 0; c_rd = 0;
  endtask

  task automatic step();
    @(negedge clk);
    if (ld_ack) c_ld++;
    if (dma_ack) begin c_dma++; seq.push_back(2'd2); end
    if (cpu_ack) begin c_cpu++; seq.push_back(2'd3); end
    if (mem_we) c_we++;
    if (mem_rd) c_rd++;
  endtask

  task automatic check_zero(input string name);
    check({name, "_grant"}, 32'(grant), 32'd0);
    check({name, "_busy"},  32'(busy), 32'd0);
    check({name, "_acks"},  32'({ld_ack, dma_ack, cpu_ack}), 32'd0);
    check({name, "_strb"},  32'({mem_we, mem_rd}), 32'd0);
    check({name, "_addr"},  32'(mem_addr), 32'd0);
    check({name, "_din"},   32'(mem_din), 32'd0);
    check({name, "_rdata"}, 32'(rdata), 32'd0);
  endtask

  initial begin
    logic [1:0] exp3 [10];
    logic [7:0] r0;
    int run, maxrun;
    exp3 = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3};
    reset = 1'b1; ld_active = 1'b0; ld_req = 1'b0; dma_req = 1'b0; cpu_req = 1'b0;
    cpu_we = 1'b0; ld_addr = '0; dma_addr = '0; cpu_addr = '0; ld_wdata = 8'h00; cpu_wdata = 8'h00;
    dmem[32'h123] = 8'h5A;
    smem[32'h123] = 8'h5A;
    clr();
    step(); step();
    check_zero("rst");
    chk_en = 1;
    reset = 1'b0;
    step();

    // CPU read, ack RD_LAT+2 cycles after the sampling cycle.
    clr();
    cpu_we = 1'b0; cpu_addr = 'h00123; cpu_req = 1'b1;
    for (int i = 1; i <= DONE_PH; i++) begin
      step();
      check("t1_grant", 32'(grant), 32'd3);
      check("t1_ack", 32'(cpu_ack), 32'(i == DONE_PH));
      if (i == 1) check("t1_rd", 32'(mem_rd), 32'd1);
      if (i == DONE_PH) check("t1_rdata", 32'(rdata), 32'h5A);
    end
    cpu_req = 1'b0;
    repeat (3) step();
    check("t1_rd_cnt", 32'(c_rd), 32'd1);

    // Loader during download with CPU and DMA held high.
    clr();
    ld_active = 1'b1; cpu_req = 1'b1; dma_req = 1'b1; dma_addr = 'h00456;
    ld_addr = 'h10000; ld_wdata = 8'hC3; ld_req = 1'b1;
    for (int i = 0; i < 20 && c_ld == 0; i++) begin
      step();
      if (mem_we) begin
        check("t2_din", 32'(mem_din), 32'hC3);
        check("t2_addr", 32'(mem_addr), 32'h10000);
      end
    end
    ld_req = 1'b0;
    check("t2_ld_ack", 32'(c_ld), 32'd1);
    repeat (8) step();
    check("t2_no_cpu_dma", 32'(c_cpu + c_dma), 32'd0);
    check("t2_rd_cnt", 32'(c_rd), 32'd0);
    check("t2_we_cnt", 32'(c_we), 32'd1);

    // Download over: DMA and CPU contend, starvation guard forces the CPU in.
    seq.delete();
    ld_active = 1'b0;
    for (int i = 0; i < 200 && seq.size() < 10; i++) step();
    cpu_req = 1'b0; dma_req = 1'b0;
    check("t3_len", 32'(seq.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      if (i < seq.size()) check($sformatf("t3_seq%0d", i), 32'(seq[i]), 32'(exp3[i]));
    run = 0; maxrun = 0;
    foreach (seq[i]) begin
      if (seq[i] == 2'd2) run++; else run = 0;
      if (run > maxrun) maxrun = run;
    end
    check("t3_gap", 32'(maxrun <= STARVE_MAX), 32'd1);

    // CPU write then read-back of the same address.
    repeat (2) step();
    clr();
    r0 = rdata;
    check("t4_r0", 32'(r0), 32'h5A);
    cpu_we = 1'b1; cpu_addr = 'h0EE00; cpu_wdata = 8'h77; cpu_req = 1'b1;
    for (int i = 1; i <= DONE_PH; i++) begin
      step();
      if (i == 1) begin
        check("t4_we", 32'(mem_we), 32'd1);
        check("t4_din", 32'(mem_din), 32'h77);
        check("t4_addr", 32'(mem_addr), 32'h0EE00);
      end
    end
    check("t4_wack", 32'(cpu_ack), 32'd1);
    check("t4_rdata_hold", 32'(rdata), 32'(r0));
    cpu_we = 1'b0;
    for (int i = 1; i <= DONE_PH + 1; i++) step();
    cpu_req = 1'b0;
    check("t4_rack", 32'(cpu_ack), 32'd1);
    check("t4_rdata", 32'(rdata), 32'h77);

    // Reset during WAIT of a DMA read abandons it.
    repeat (2) step();
    clr();
    dma_addr = 'h00456; dma_req = 1'b1;
    step(); step();
    reset = 1'b1; dma_req = 1'b0;
    step();
    check_zero("t5");
    reset = 1'b0;
    repeat (4) step();
    check("t5_no_ack", 32'(c_dma), 32'd0);
    dma_req = 1'b1;
    for (int i = 0; i < 20 && c_dma == 0; i++) step();
    dma_req = 1'b0;
    check("t5_ack", 32'(c_dma), 32'd1);
    check("t5_rdata", 32'(rdata), 32'h6A);

    // CPU request dropped right after the grant still completes once.
    repeat (2) step();
    clr();
    cpu_we = 1'b0; cpu_addr = 'h00200; cpu_req = 1'b1;
    step();
    cpu_req = 1'b0;
    repeat (8) step();
    check("t6_ack_cnt", 32'(c_cpu), 32'd1);
    check("t6_rd_cnt", 32'(c_rd), 32'd1);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
